// File: rtl/opb_register_simulink2ppc.sv
// OPB slave exposing a fabric-captured 32-bit value, a capture counter and a freeze control to the PPC.
// Fixed three-phase transfer (IDLE -> ACK -> GAP); the fabric side shares OPB_Clk.
module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h01000B00,
    parameter logic [31:0] C_HIGHADDR   = 32'h01000BFF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [31:0]               user_data_in,
    input  logic                      user_valid,
    output logic                      user_freeze
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_take;

    logic [1:0]  r_word;
    logic        r_rnw;
    logic        r_be3;
    logic [1:0]  r_wbits;
    logic [31:0] r_rdata;

    logic [31:0] r_data;
    logic [31:0] r_count;
    logic        r_freeze;

    logic        w_hit;
    logic [1:0]  w_word;
    logic [31:0] w_wdata;
    logic [31:0] w_rd_mux;
    logic        w_in_ack;
    logic        w_ctrl_wr;
    logic        w_clear;
    logic        w_capture;
    logic        w_unused;

    // DBus bit 0 is the MSB, so a plain vector copy gives reg bit k <-> DBus bit 31-k.
    assign w_wdata = OPB_DBus;
    assign w_word  = OPB_ABus[28:29];
    assign w_hit   = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);

    always_comb begin
        w_rd_mux = '0;
        case (w_word)
            2'd0:    w_rd_mux = r_data;
            2'd1:    w_rd_mux = r_count;
            2'd2:    w_rd_mux = {31'b0, r_freeze};
            default: w_rd_mux = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_next = S_ACK;
                    w_take       = 1'b1;
                end
            end
            S_ACK:   w_state_next = S_GAP;
            S_GAP:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_word  <= 2'd0;
            r_rnw   <= 1'b0;
            r_be3   <= 1'b0;
            r_wbits <= 2'd0;
            r_rdata <= '0;
        end else if (w_take) begin
            r_word  <= w_word;
            r_rnw   <= OPB_RNW;
            r_be3   <= OPB_BE[3];
            r_wbits <= w_wdata[1:0];
            r_rdata <= OPB_RNW ? w_rd_mux : 32'd0;
        end else begin
            r_rdata <= '0;
        end
    end

    // Reset is also gated in combinationally so a reset landing in ACK suppresses the ack itself.
    assign w_in_ack  = (r_state == S_ACK) && !OPB_Rst;
    assign w_ctrl_wr = w_in_ack && !r_rnw && (r_word == 2'd2) && r_be3;
    assign w_clear   = w_ctrl_wr && r_wbits[1];
    assign w_capture = user_valid && !r_freeze;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_data   <= '0;
            r_count  <= '0;
            r_freeze <= 1'b0;
        end else begin
            if (w_capture) begin
                r_data <= user_data_in;
            end
            if (w_clear) begin
                r_count <= '0;
            end else if (w_capture) begin
                r_count <= r_count + 32'd1;
            end
            if (w_ctrl_wr) begin
                r_freeze <= r_wbits[0];
            end
        end
    end

    assign Sl_xferAck  = w_in_ack;
    assign Sl_DBus     = w_in_ack ? r_rdata : 32'd0;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_freeze = r_freeze;

    assign w_unused = ^{OPB_seqAddr, OPB_ABus[30:31], OPB_BE[0:2], w_wdata[31:2]} ^ (C_FAMILY != "");

endmodule
